// File: rtl/dc_hyper_pkg.sv
// Shared one-hot pointer helpers for the HyperBus dual-clock FIFO trackers.
// Vectors are zero-extended to MAX_W so one set of functions serves any ring size.
package dc_hyper_pkg;

  localparam int MAX_W = 64;
  typedef logic [MAX_W-1:0] vec_t;

  function automatic int unsigned onehot_to_idx(input vec_t v);
    int unsigned idx;
    idx = 0;
    for (int i = 0; i < MAX_W; i++) begin
      if (v[i]) idx = idx | unsigned'(i);
    end
    return idx;
  endfunction

  function automatic logic is_onehot(input vec_t v);
    int cnt;
    cnt = 0;
    for (int i = 0; i < MAX_W; i++) begin
      if (v[i]) cnt++;
    end
    return (cnt == 1);
  endfunction

  // Rotate left by one within an n-bit ring: bit n-1 wraps to bit 0.
  function automatic vec_t rotl1(input vec_t v, input int n);
    vec_t r;
    r = '0;
    for (int i = 0; i < MAX_W; i++) begin
      if (i < n) r[(i + 1 == n) ? 0 : i + 1] = v[i];
    end
    return r;
  endfunction

endpackage

// File: rtl/dc_sync_pipe_hyper.sv
// Flop chain for an asynchronous bus; the last stage loads only when enabled,
// and its D input is exported so the parent can qualify it.
module dc_sync_pipe_hyper #(
  parameter int WIDTH = 8,
  parameter int STAGES = 2,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  input  logic             load,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] final_d
);

  logic [STAGES*WIDTH-1:0]     pipe_q;
  logic [(STAGES+1)*WIDTH-1:0] in_vec;

  // Slice i of in_vec is the D input of stage i.
  assign in_vec  = {pipe_q, d};
  assign final_d = in_vec[(STAGES-1)*WIDTH +: WIDTH];
  assign q       = pipe_q[(STAGES-1)*WIDTH +: WIDTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_q <= {STAGES{RESET_VALUE}};
    end else begin
      for (int i = 0; i < STAGES - 1; i++) begin
        pipe_q[i*WIDTH +: WIDTH] <= in_vec[i*WIDTH +: WIDTH];
      end
      if (load) pipe_q[(STAGES-1)*WIDTH +: WIDTH] <= final_d;
    end
  end

endmodule

// File: rtl/dc_write_tracker_hyper.sv
// Write-domain occupancy tracker: one-hot write pointer, synchronised one-hot
// read pointer, exact free-slot count with full / almost-full and push handshake.
module dc_write_tracker_hyper
  import dc_hyper_pkg::*;
#(
  parameter int BUFFER_DEPTH = 8,
  parameter int SYNC_STAGES = 2,
  localparam int CNT_W = $clog2(BUFFER_DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    valid_i,
  output logic                    ready_o,
  output logic [BUFFER_DEPTH-1:0] write_pointer_o,
  input  logic [BUFFER_DEPTH-1:0] read_pointer_i,
  input  logic [CNT_W-1:0]        margin_i,
  output logic [CNT_W-1:0]        free_o,
  output logic                    full_o,
  output logic                    almost_full_o,
  output logic                    ptr_err_o
);

  localparam logic [BUFFER_DEPTH-1:0] PTR_INIT = {{(BUFFER_DEPTH-1){1'b0}}, 1'b1};

  logic [BUFFER_DEPTH-1:0] wr_q, rd_q, final_d;
  logic [CNT_W-1:0]        wr_idx, rd_idx, used;
  logic                    final_ok, push, ptr_err_q;
  vec_t                    wr_ext, rd_ext, fd_ext, rot_ext;

  dc_sync_pipe_hyper #(
    .WIDTH       (BUFFER_DEPTH),
    .STAGES      (SYNC_STAGES),
    .RESET_VALUE (PTR_INIT)
  ) u_rd_sync (
    .clk     (clk),
    .rst     (rst),
    .d       (read_pointer_i),
    .load    (final_ok),
    .q       (rd_q),
    .final_d (final_d)
  );

  always_comb begin
    wr_ext = '0;
    rd_ext = '0;
    fd_ext = '0;
    wr_ext[BUFFER_DEPTH-1:0] = wr_q;
    rd_ext[BUFFER_DEPTH-1:0] = rd_q;
    fd_ext[BUFFER_DEPTH-1:0] = final_d;
    rot_ext  = rotl1(wr_ext, BUFFER_DEPTH);
    final_ok = is_onehot(fd_ext);
    wr_idx   = CNT_W'(onehot_to_idx(wr_ext));
    rd_idx   = CNT_W'(onehot_to_idx(rd_ext));
  end

  // Modular distance; one slot is always kept empty so rd == rotl(wr) is full.
  assign used          = wr_idx - rd_idx;
  assign free_o        = CNT_W'(BUFFER_DEPTH - 1) - used;
  assign full_o        = (free_o == '0);
  assign almost_full_o = (free_o <= margin_i);
  assign ready_o       = ~full_o;
  assign push          = valid_i & ready_o;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q      <= PTR_INIT;
      ptr_err_q <= 1'b0;
    end else begin
      if (push) wr_q <= rot_ext[BUFFER_DEPTH-1:0];
      if (!final_ok) ptr_err_q <= 1'b1;
    end
  end

  assign write_pointer_o = wr_q;
  assign ptr_err_o       = ptr_err_q;

endmodule
